// File: rtl/fft_twiddle_mac.sv
// -----------------------------------------------------------------------------
// fft_twiddle_mac
//   Complex multiply-accumulate stage that sits after the FFT control unit.
//   Each accepted sample is multiplied by a twiddle factor read from an
//   8-entry Q1.15 ROM, rounded back to sample scale and summed into wide
//   accumulators. Every N_TERMS accepted samples one saturated complex result
//   is emitted for the X memory write port.
//
//   Pipeline: S1 (sample + twiddle) -> S2 (rounded product) -> S3 (product
//   staged for the accumulator) -> accumulate / emit. The last sample accepted
//   at edge t produces out_valid after edge t+3.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   Local_reset  synchronous active-high clear, beats in_valid
//   in_valid     sample strobe, one sample per high cycle
//   in_re/in_im  signed sample, DW bits each
//   ROMW_add     twiddle index k (0..7), sampled with in_valid
//   out_valid    one-cycle result strobe
//   out_re/out_im saturated signed result, DW bits each
//   Overflow     sticky flag: some emitted result was clamped
// -----------------------------------------------------------------------------
module fft_twiddle_mac #(
  parameter int DW      = 16,
  parameter int TW      = 16,
  parameter int N_TERMS = 8,
  parameter int ACC_W   = 22
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Local_reset,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  input  logic [2:0]           ROMW_add,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic                 Overflow
);

  localparam int MW = DW + TW;          // single product width
  localparam int PW = DW + TW + 1;      // sum/difference of two products
  localparam int RW = PW - (TW - 1);    // product after dropping Q1.15 fraction
  localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

  localparam logic signed [PW-1:0]    RND     = PW'(2 ** (TW - 2));
  localparam logic signed [ACC_W-1:0] SUM_MAX = ACC_W'(2 ** (DW - 1) - 1);
  localparam logic signed [ACC_W-1:0] SUM_MIN = ACC_W'(-(2 ** (DW - 1)));
  localparam logic signed [DW-1:0]    OUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]    OUT_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [CW-1:0]           LAST    = CW'(N_TERMS - 1);

  // Twiddle ROM: W_k = exp(-j*2*pi*k/8) in Q1.15
  logic signed [TW-1:0] w_re, w_im;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_re = '0;
    w_im = '0;
    case (ROMW_add)
      3'd0: begin w_re = TW'(32767);  w_im = TW'(0);      end
      3'd1: begin w_re = TW'(23170);  w_im = TW'(-23170); end
      3'd2: begin w_re = TW'(0);      w_im = TW'(-32767); end
      3'd3: begin w_re = TW'(-23170); w_im = TW'(-23170); end
      3'd4: begin w_re = TW'(-32767); w_im = TW'(0);      end
      3'd5: begin w_re = TW'(-23170); w_im = TW'(23170);  end
      3'd6: begin w_re = TW'(0);      w_im = TW'(32767);  end
      3'd7: begin w_re = TW'(23170);  w_im = TW'(23170);  end
      default: begin w_re = '0;       w_im = '0;          end
    endcase
  end

  // Pipeline state
  logic                    s1_valid_q, s2_valid_q, s3_valid_q;
  logic signed [DW-1:0]    s1_re_q, s1_im_q;
  logic signed [TW-1:0]    s1_wre_q, s1_wim_q;
  logic signed [RW-1:0]    s2_re_q, s2_im_q, s3_re_q, s3_im_q;
  logic signed [ACC_W-1:0] acc_re_q, acc_im_q;
  logic [CW-1:0]           cnt_q;
  logic                    out_valid_q, ovf_q;
  logic signed [DW-1:0]    out_re_q, out_im_q;

  // S2 datapath: exact complex product, round-half-up, drop the fraction bits
  logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [PW-1:0] prod_re, prod_im;
  logic signed [RW-1:0] p_re_d, p_im_d;

  assign m_rr    = MW'(s1_re_q) * MW'(s1_wre_q);
  assign m_ii    = MW'(s1_im_q) * MW'(s1_wim_q);
  assign m_ri    = MW'(s1_re_q) * MW'(s1_wim_q);
  assign m_ir    = MW'(s1_im_q) * MW'(s1_wre_q);
  assign prod_re = PW'(m_rr) - PW'(m_ii) + RND;
  assign prod_im = PW'(m_ri) + PW'(m_ir) + RND;
  // Taking the upper bits is the arithmetic shift right by TW-1
  assign p_re_d  = prod_re[PW-1:TW-1];
  assign p_im_d  = prod_im[PW-1:TW-1];

  // Accumulate stage: running sum including the product currently in S3
  logic signed [ACC_W-1:0] sum_re_d, sum_im_d;
  logic signed [DW-1:0]    sat_re_d, sat_im_d;
  logic                    clip_re_d, clip_im_d;

  assign sum_re_d = acc_re_q + ACC_W'(s3_re_q);
  assign sum_im_d = acc_im_q + ACC_W'(s3_im_q);

  always_comb begin
    sat_re_d  = sum_re_d[DW-1:0];
    sat_im_d  = sum_im_d[DW-1:0];
    clip_re_d = 1'b0;
    clip_im_d = 1'b0;
    if (sum_re_d > SUM_MAX) begin
      sat_re_d  = OUT_MAX;
      clip_re_d = 1'b1;
    end else if (sum_re_d < SUM_MIN) begin
      sat_re_d  = OUT_MIN;
      clip_re_d = 1'b1;
    end
    if (sum_im_d > SUM_MAX) begin
      sat_im_d  = OUT_MAX;
      clip_im_d = 1'b1;
    end else if (sum_im_d < SUM_MIN) begin
      sat_im_d  = OUT_MIN;
      clip_im_d = 1'b1;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every stage samples the values its predecessor held before this edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
      s1_wre_q    <= '0;
      s1_wim_q    <= '0;
      s2_re_q     <= '0;
      s2_im_q     <= '0;
      s3_re_q     <= '0;
      s3_im_q     <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      ovf_q       <= 1'b0;
    end else if (Local_reset) begin
      // Drops in-flight samples too, so a final term arriving now is lost
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
      s1_wre_q    <= '0;
      s1_wim_q    <= '0;
      s2_re_q     <= '0;
      s2_im_q     <= '0;
      s3_re_q     <= '0;
      s3_im_q     <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_re_q  <= in_re;
        s1_im_q  <= in_im;
        s1_wre_q <= w_re;
        s1_wim_q <= w_im;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_re_q <= p_re_d;
        s2_im_q <= p_im_d;
      end
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        s3_re_q <= s2_re_q;
        s3_im_q <= s2_im_q;
      end

      out_valid_q <= 1'b0;
      if (s3_valid_q) begin
        if (cnt_q == LAST) begin
          out_valid_q <= 1'b1;
          out_re_q    <= sat_re_d;
          out_im_q    <= sat_im_d;
          acc_re_q    <= '0;
          acc_im_q    <= '0;
          cnt_q       <= '0;
          if (clip_re_d || clip_im_d) ovf_q <= 1'b1;
        end else begin
          acc_re_q <= sum_re_d;
          acc_im_q <= sum_im_d;
          cnt_q    <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_fft_twiddle_mac.sv
// -----------------------------------------------------------------------------
// tb_fft_twiddle_mac
//   Self-checking bench for fft_twiddle_mac. Inputs are driven on the falling
//   edge and outputs observed on the falling edge. A monitor compares every
//   out_valid pulse against a queue of expected results, filled either from a
//   directed vector table or from a group-level arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fft_twiddle_mac;

  localparam int N = 8;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               Local_reset = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_re = '0;
  logic signed [15:0] in_im = '0;
  logic [2:0]         ROMW_add = '0;
  logic               out_valid;
  logic signed [15:0] out_re, out_im;
  logic               Overflow;

  always #5 clock = ~clock;

  fft_twiddle_mac #(.DW(16), .TW(16), .N_TERMS(N), .ACC_W(22)) dut (
    .clock       (clock),
    .reset       (reset),
    .Local_reset (Local_reset),
    .in_valid    (in_valid),
    .in_re       (in_re),
    .in_im       (in_im),
    .ROMW_add    (ROMW_add),
    .out_valid   (out_valid),
    .out_re      (out_re),
    .out_im      (out_im),
    .Overflow    (Overflow)
  );

  typedef struct {
    int re;
    int im;
    int ovf;
  } exp_t;

  typedef struct {
    int a_re;
    int a_im;
    int k;
    int e_re;
    int e_im;
    int e_ovf;
  } vec_t;

  localparam int W_RE [8] = '{32767, 23170, 0, -23170, -32767, -23170, 0, 23170};
  localparam int W_IM [8] = '{0, -23170, -32767, -23170, 0, 23170, 32767, 23170};

  exp_t  exp_q[$];
  vec_t  vecs[4];
  int    errors = 0;
  int    checks = 0;
  int    n_results = 0;
  int    n_expected = 0;

  // Group-level reference model
  int    m_cnt = 0;
  longint m_sre = 0;
  longint m_sim = 0;
  int    m_ovf = 0;
  bit    push_model = 1'b1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic longint round_q15(input longint p);
    return (p + 64'sd16384) >>> 15;
  endfunction

  function automatic int clamp16(input longint s);
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return int'(s);
  endfunction

  task automatic model_clear();
    m_cnt = 0;
    m_sre = 0;
    m_sim = 0;
    m_ovf = 0;
  endtask

  // Presents one sample for the next rising edge and folds it into the model
  task automatic drive_sample(input int re, input int im, input int k);
    int r, i;
    @(negedge clock);
    in_valid = 1'b1;
    in_re    = 16'(re);
    in_im    = 16'(im);
    ROMW_add = 3'(k);
    m_sre += round_q15(longint'(re) * W_RE[k] - longint'(im) * W_IM[k]);
    m_sim += round_q15(longint'(re) * W_IM[k] + longint'(im) * W_RE[k]);
    m_cnt++;
    if (m_cnt == N) begin
      r = clamp16(m_sre);
      i = clamp16(m_sim);
      if (longint'(r) != m_sre || longint'(i) != m_sim) m_ovf = 1;
      if (push_model) begin
        exp_q.push_back('{re: r, im: i, ovf: m_ovf});
        n_expected++;
      end
      m_cnt = 0;
      m_sre = 0;
      m_sim = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  function automatic int rand_val();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 8000)) - 4000;
  endfunction

  task automatic rand_group(input bit gaps);
    for (int s = 0; s < N; s++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      drive_sample(rand_val(), rand_val(), int'($urandom_range(0, 7)));
    end
  endtask

  task automatic drain(input string name);
    idle(6);
    check(name, exp_q.size(), 0);
  endtask

  // Result monitor
  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      exp_t e;
      n_results++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got out=(%0d,%0d) expected no result",
                 out_re, out_im);
      end else begin
        e = exp_q.pop_front();
        check("out_re", out_re, e.re);
        check("out_im", out_im, e.im);
        check("overflow_at_result", Overflow, e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;

    vecs[0] = '{a_re: 1000,  a_im: 0,    k: 2, e_re: 0,     e_im: -8000, e_ovf: 0};
    vecs[1] = '{a_re: 0,     a_im: 1000, k: 1, e_re: 5656,  e_im: 5656,  e_ovf: 0};
    vecs[2] = '{a_re: 32767, a_im: 0,    k: 0, e_re: 32767, e_im: 0,     e_ovf: 1};
    vecs[3] = '{a_re: 1000,  a_im: 0,    k: 0, e_re: 8000,  e_im: 0,     e_ovf: 1};

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_overflow", Overflow, 0);
    reset = 1'b1;
    model_clear();

    // Latency of a single group: out_valid after the third edge past the 8th sample
    for (int s = 0; s < N; s++) drive_sample(1000, 0, 0);
    @(negedge clock); in_valid = 1'b0;
    check("lat_edge_t", out_valid, 0);
    @(negedge clock);
    check("lat_edge_t1", out_valid, 0);
    @(negedge clock);
    check("lat_edge_t2", out_valid, 0);
    @(negedge clock);
    check("lat_edge_t3", out_valid, 1);
    idle(2);

    // Directed vector table, groups back-to-back
    push_model = 1'b0;
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back('{re: vecs[v].e_re, im: vecs[v].e_im, ovf: vecs[v].e_ovf});
      n_expected++;
      for (int s = 0; s < N; s++) drive_sample(vecs[v].a_re, vecs[v].a_im, vecs[v].k);
    end
    push_model = 1'b1;
    drain("table_drain");
    check("overflow_sticky", Overflow, 1);

    // Local_reset clears the sticky flag
    @(negedge clock); Local_reset = 1'b1;
    @(negedge clock); Local_reset = 1'b0;
    model_clear();
    check("overflow_cleared", Overflow, 0);
    check("lr_out_re_cleared", out_re, 0);

    // Random groups: two back-to-back, then two with bubbles
    rand_group(1'b0);
    rand_group(1'b0);
    rand_group(1'b1);
    rand_group(1'b1);
    drain("random_drain");

    // Local_reset after sample 5 discards the partial group
    for (int s = 0; s < 5; s++) drive_sample(rand_val(), rand_val(), int'($urandom_range(0, 7)));
    @(negedge clock); in_valid = 1'b0; Local_reset = 1'b1;
    @(negedge clock); Local_reset = 1'b0;
    model_clear();
    rand_group(1'b0);
    drain("lr_mid_group_drain");

    // Local_reset coinciding with the final term: clear wins
    push_model = 1'b0;
    for (int s = 0; s < N; s++) drive_sample(1000, 0, 0);
    @(negedge clock); in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock); Local_reset = 1'b1;
    @(negedge clock); Local_reset = 1'b0;
    check("clear_wins_out_valid", out_valid, 0);
    push_model = 1'b1;
    model_clear();
    for (int s = 0; s < N; s++) drive_sample(0, 1000, 1);
    drain("after_clear_drain");

    // Async reset mid-group while outputs hold non-zero values
    for (int s = 0; s < N; s++) drive_sample(32767, 0, 0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      in_valid = 1'b0;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("sat_result_seen", seen, 1);
    for (int s = 0; s < 3; s++) drive_sample(rand_val(), rand_val(), int'($urandom_range(0, 7)));
    @(posedge clock);
    #2;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_re", out_re, 0);
    check("async_rst_out_im", out_im, 0);
    check("async_rst_overflow", Overflow, 0);
    model_clear();
    @(negedge clock); reset = 1'b1;
    rand_group(1'b0);
    drain("post_reset_drain");

    check("result_count", n_results, n_expected);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_twiddle_mac.md
Name: fft_twiddle_mac

Overview:
- Datapath stage directly downstream of the FFT control unit.
- Consumes the control unit's MAC_IN_Sel-selected sample stream, ROMW_add twiddle address and Local_reset. Returns the Overflow status the control unit samples.
- Holds the 8-entry twiddle ROM and performs a complex multiply-accumulate over N_TERMS samples per output bin. Emits one complex result per group toward the X memory write port.

Parameters:
- DW, 16, sample and result width (signed, two's complement)
- TW, 16, twiddle width (signed Q1.15)
- N_TERMS, 8, accepted samples per output bin
- ACC_W, 22, accumulator width (DW+6)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Local_reset  in  1  synchronous clear from the control unit, active-high
- in_valid  in  1  sample strobe; one sample accepted per high cycle
- in_re  in  DW  sample real part
- in_im  in  DW  sample imaginary part
- ROMW_add  in  3  twiddle index k, sampled with in_valid
- out_valid  out  1  one-cycle result strobe
- out_re  out  DW  saturated result, real part
- out_im  out  DW  saturated result, imaginary part
- Overflow  out  1  sticky saturation flag

Behaviour:
- Reset values: reset low clears all pipeline registers, the term counter and the accumulators. out_valid=0, out_re=0, out_im=0, Overflow=0.
- Local_reset=1 at a rising edge has the same clearing effect, synchronously, and takes priority over in_valid that cycle.
- Twiddle ROM (re,im), entries k=0..7:
  - k0 (32767,0), k1 (23170,-23170), k2 (0,-32767), k3 (-23170,-23170)
  - k4 (-32767,0), k5 (-23170,23170), k6 (0,32767), k7 (23170,23170)
- Pipeline, three stages:
  - S1: register sample and ROM word when in_valid=1, plus a valid bit.
  - S2: full-precision products p_re=a_re*w_re-a_im*w_im and p_im=a_re*w_im+a_im*w_re (2*DW+1 bits). Round: add 2^14, then arithmetic shift right by 15. Register the result with a valid bit.
  - S3: accumulate the rounded product into the ACC_W-bit accumulators.
- Term counter 0..N_TERMS-1 advances on each S3-valid cycle.
- When the S3-valid term is the last one (count=N_TERMS-1):
  - the saturated output (accumulator + current product) is registered to out_re/out_im;
  - out_valid=1 for one cycle;
  - the accumulator reloads to 0 and the counter wraps to 0.
- Back-to-back groups lose no cycle: the first sample of the next group may be accepted on the cycle right after the previous group's last sample.
- Latency: last sample accepted at edge t gives out_valid=1 after edge t+3.
- Gaps: in_valid low cycles insert bubbles; the accumulator and counter hold.
- Saturation: a final sum above 2^(DW-1)-1 clamps to 32767; a sum below -2^(DW-1) clamps to -32768.
- Overflow:
  - set on the edge where out_valid rises with either part clamped;
  - stays 1 until reset or Local_reset;
  - out_valid and the clamped data still appear normally.
- The ACC_W width is chosen so the accumulator never wraps for N_TERMS ≤ 8.
- Simultaneous Local_reset and a final term: the clear wins; no out_valid is produced.
- Reset asserted mid-group: the partial sum is discarded, and the next valid sample counts as term 0.

Test Plan:
- Async reset pulse low mid-clock with outputs busy -> all outputs 0 immediately, no clock needed. After release, the first valid starts term 0.
- 8 samples (1000,0), k=0, consecutive cycles -> exactly one out_valid, 3 cycles after the 8th sample, out=(8000,0), Overflow=0.
- 8 samples (1000,0), k=2 -> out=(0,-8000). 8 samples (0,1000), k=1 -> each product (23170*1000+16384)>>15 = 707 per part, out=(5656,5656).
- 8 samples (32767,0), k=0 -> each product 32766, out=(32767,0) saturated, Overflow=1. Overflow stays 1 through a following clean group (out=(8000,0)) until a Local_reset pulse clears it.
- Two groups back-to-back, then a group with random in_valid gaps -> out_valid exactly once per 8 accepted samples. Results match the reference model with no cross-group leakage.
- Local_reset asserted after sample 5 of a group -> no out_valid for that group. The next 8 samples produce the correct independent result.
